// File: rtl/mdu_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
package mdu_pkg;

    localparam int XLEN      = 32;
    localparam int MDU_ITERS = 32;

    localparam logic [31:0] DIV_BY_ZERO_Q = '1;
    localparam logic [31:0] INT_MIN       = 32'h8000_0000;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } mdu_op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIXUP,
        S_DONE
    } mdu_state_e;

    function automatic logic rs1_signed(mdu_op_e o);
        return o inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic rs2_signed(mdu_op_e o);
        return o inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
    endfunction

endpackage

// File: rtl/mdu_iter_datapath.sv
// Shared shift-add multiply / restoring divide datapath, one iteration per step.
module mdu_iter_datapath #(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              step,
    input  logic              is_div,
    input  logic [XLEN-1:0]   lo_in,
    input  logic [XLEN-1:0]   m_in,
    output logic [2*XLEN-1:0] prod,
    output logic [XLEN-1:0]   quot,
    output logic [XLEN-1:0]   rem
);

    // Upper half: accumulator / partial remainder.
    // Lower half: multiplier / dividend shifting into quotient.
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   m_q;
    logic [XLEN:0]     sum;
    logic [XLEN:0]     shifted;
    logic [XLEN:0]     trial;
    logic              ge;

    always_comb begin
        sum     = {1'b0, acc[2*XLEN-1:XLEN]}
                + (acc[0] ? {1'b0, m_q} : '0);
        shifted = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        trial   = shifted - {1'b0, m_q};
        // Partial remainder stays below 2*divisor, so bit XLEN is the borrow.
        ge      = ~trial[XLEN];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc <= '0;
            m_q <= '0;
        end else if (load) begin
            acc <= {{XLEN{1'b0}}, lo_in};
            m_q <= m_in;
        end else if (step) begin
            if (is_div) begin
                acc <= {ge ? trial[XLEN-1:0] : shifted[XLEN-1:0],
                        acc[XLEN-2:0], ge};
            end else begin
                acc <= {sum, acc[XLEN-1:1]};
            end
        end
    end

    assign prod = acc;
    assign quot = acc[XLEN-1:0];
    assign rem  = acc[2*XLEN-1:XLEN];

endmodule

// File: rtl/mdu_sequencer.sv
// RV32M sequencer: FSM, sign handling, fast paths and result fixup
// around the shared iterative datapath.
module mdu_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            flush,
    output logic            stall_req,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    import mdu_pkg::*;

    mdu_state_e state, state_nx;
    mdu_op_e    op_in, op_q;
    logic       neg_res_q, neg_rem_q;
    logic [4:0] cnt;

    logic            neg1, neg2;
    logic [XLEN-1:0] mag1, mag2;
    logic            accept, load, step;
    logic            div_zero, div_ovf, fast;
    logic [XLEN-1:0] fast_val, fix_val;
    logic [XLEN-1:0] dp_lo, dp_m;

    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0]   quot, rem, quot_s, rem_s;

    assign op_in = mdu_op_e'(op);
    assign neg1  = rs1_signed(op_in) & rs1[XLEN-1];
    assign neg2  = rs2_signed(op_in) & rs2[XLEN-1];
    assign mag1  = neg1 ? -rs1 : rs1;
    assign mag2  = neg2 ? -rs2 : rs2;

    assign accept   = (state == S_IDLE) & start & ~flush;
    assign div_zero = op[2] & (rs2 == '0);
    assign div_ovf  = (op_in == OP_DIV || op_in == OP_REM)
                    & (rs1 == INT_MIN) & (rs2 == '1);
    assign fast     = div_zero | div_ovf;
    assign load     = accept & ~fast;
    assign step     = (state == S_CALC);

    always_comb begin
        fast_val = '0;
        unique case (1'b1)
            div_zero & ~op[1]: fast_val = DIV_BY_ZERO_Q;
            div_zero &  op[1]: fast_val = rs1;
            ~div_zero & ~op[1]: fast_val = INT_MIN;
            default:           fast_val = '0;
        endcase
    end

    // Multiply streams the multiplier through the low half.
    assign dp_lo = op[2] ? mag1 : mag2;
    assign dp_m  = op[2] ? mag2 : mag1;

    mdu_iter_datapath #(.XLEN(XLEN)) u_dp (
        .clk    (clk),
        .reset  (reset),
        .load   (load),
        .step   (step),
        .is_div (op_q[2]),
        .lo_in  (dp_lo),
        .m_in   (dp_m),
        .prod   (prod),
        .quot   (quot),
        .rem    (rem)
    );

    assign prod_s = neg_res_q ? -prod : prod;
    assign quot_s = neg_res_q ? -quot : quot;
    assign rem_s  = neg_rem_q ? -rem  : rem;

    always_comb begin
        fix_val = rem_s;
        case (op_q)
            OP_MUL:                       fix_val = prod_s[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_val = prod_s[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              fix_val = quot_s;
            default:                      fix_val = rem_s;
        endcase
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:  if (accept) state_nx = fast ? S_DONE : S_CALC;
            S_CALC:  if (cnt == 5'(MDU_ITERS - 1)) state_nx = S_FIXUP;
            S_FIXUP: state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
        if (flush) state_nx = S_IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q      <= OP_MUL;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            cnt       <= '0;
            result    <= '0;
        end else begin
            if (load) begin
                op_q      <= op_in;
                neg_res_q <= neg1 ^ neg2;
                neg_rem_q <= neg1;
                cnt       <= '0;
            end else if (state == S_CALC) begin
                cnt <= cnt + 5'd1;
            end
            if (accept & fast) begin
                result <= fast_val;
            end else if ((state == S_FIXUP) & ~flush) begin
                result <= fix_val;
            end
        end
    end

    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign stall_req = accept | (state == S_CALC) | (state == S_FIXUP);

endmodule

// File: doc/mdu_sequencer.md
# mdu_sequencer

Iterative RV32M multiply/divide unit: one shared shift-add / restoring-divide datapath is sequenced by an FSM for all eight M-extension ops. It sits in the EXE stage beside the ALU. It holds the pipeline through `stall_req` until the result is ready, so the hazard logic sees a single in-flight M-op. The whole-pipeline stall is what gives it that single-op view.

## Interface
- `XLEN`, default 32: operand/result width. Only 32 is supported.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `start` input 1: issue request. Sampled only in IDLE.
- `op` input 3: funct3. 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `rs1` input XLEN: dividend / multiplicand.
- `rs2` input XLEN: divisor / multiplier.
- `flush` input 1: branch/trap flush. Aborts any op.
- `stall_req` output 1: freezes IF/ID/EXE while an op is accepted or in progress.
- `busy` output 1: state != IDLE.
- `done` output 1: one-cycle pulse; `result` is valid in this cycle.
- `result` output XLEN: registered result. Holds its value until the next `done`.

## Operation
- FSM states: IDLE, CALC, FIXUP, DONE.
- IDLE -> CALC when `start & ~flush`. On this transition:
  - latch `op`;
  - latch |rs1| and |rs2| per op signedness (MULHSU: rs1 signed, rs2 unsigned);
  - latch result sign;
  - clear the 5-bit iteration counter.
- IDLE -> DONE directly (fast path) for these cases:
  - DIV/DIVU with rs2 = 0: result 0xFFFFFFFF.
  - REM/REMU with rs2 = 0: result = rs1.
  - DIV with rs1 = 0x80000000 and rs2 = 0xFFFFFFFF: result 0x80000000.
  - REM with rs1 = 0x80000000 and rs2 = 0xFFFFFFFF: result 0.
- CALC runs one iteration per cycle. It moves to FIXUP when the counter reaches 31 (32 iterations).
  - Multiply: 64-bit product register, unsigned shift-add on magnitudes.
  - Divide: restoring algorithm with a 33-bit trial subtract, giving a 32-bit quotient and a 32-bit remainder.
- FIXUP applies sign correction, then selects the output and loads it into `result`.
  - Multiply: negate the 64-bit product if the sign is set.
  - Signed DIV: quotient negative if signs differ.
  - Signed REM: remainder takes the dividend's sign.
  - Output select: MUL low 32 bits; MULH* high 32 bits; DIV* quotient; REM* remainder.
- DONE: `done = 1` for exactly one cycle, then IDLE.
- `stall_req = (IDLE & start & ~flush) | CALC | FIXUP`. It is low in DONE so the pipeline advances and captures `result`.
- `start` outside IDLE is ignored. The pipeline is stalled, so it must not change.
- `flush` in any state: next state is IDLE, no `done`, `result` unchanged.
- `flush` and `start` together in IDLE: flush wins and the op is not accepted.
- `reset` asserted at any time: immediate return to IDLE, with `busy = 0`, `done = 0`, `result = 0`, counter 0. While in reset, `stall_req` follows `start & ~flush`.

## Timing
- Normal path: `start` sampled at edge T.
  - CALC during cycles T+1..T+32.
  - FIXUP during cycle T+33.
  - DONE during cycle T+34, with `done` high and `result` valid.
  - IDLE at T+35. A new `start` can be accepted at edge T+35.
- Fast path: DONE during cycle T+1, IDLE at T+2.
- `stall_req` is combinational from `start` in IDLE. It is asserted in cycle T itself, so the issuing instruction stays in EXE.
- `result`, `done` and `busy` are registered outputs with no combinational paths from inputs.

## Structure
- Shared package `mdu_pkg`:
  - `mdu_op_e` enum (8 funct3 encodings);
  - `mdu_state_e` enum;
  - `XLEN`, `MDU_ITERS = 32`;
  - constants `DIV_BY_ZERO_Q = '1` and `INT_MIN = 32'h8000_0000`.
- One sub-module `mdu_iter_datapath`:
  - holds the product/remainder/quotient registers and does one iteration per `step` pulse;
  - exposes the raw unsigned results to the sequencer.
- FSM, counter, sign/fast-path logic and FIXUP live in `mdu_sequencer`.

## Test plan
- MUL 7 × 0xFFFFFFFD (-3), `start` at T -> `stall_req` high T..T+33; `done` at T+34 with `result` 0xFFFFFFEB; `busy` low at T+35.
- MULH 0x80000000 × 0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 100/0 -> `done` at T+1, `result` 0xFFFFFFFF. REMU 100/0 -> 100. DIV 0x80000000/0xFFFFFFFF -> 0x80000000 at T+1. REM of the same operands -> 0.
- DIV -7/2 -> 0xFFFFFFFD (-3). REM -7/2 -> 0xFFFFFFFF (-1). DIVU 0xFFFFFFFF/2 -> 0x7FFFFFFF. All at T+34.
- `flush` at T+10 during CALC -> IDLE at T+11, no `done`, `result` keeps its previous value. A new `start` at T+11 completes normally at T+45.
- `reset` pulsed at T+20 -> `busy`, `done` and `result` are 0 immediately. `start` together with `flush` in IDLE -> not accepted, `busy` stays 0.
